// File: rtl/mem_access_master.sv
// Load/store bus initiator: one byte/half/word access at a time, fixed-length bus phases.
// Latency: read READ_LATENCY+1, write WRITE_CYCLES+1, fault 1 cycle; new requests are accepted only in IDLE.
module mem_access_master #(
    parameter int READ_LATENCY = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oMisaligned,
    output logic [31:0] oRData,
    output logic        wReadEnable,
    output logic        wWriteEnable,
    output logic [3:0]  wByteEnable,
    output logic [31:0] wAddress,
    output logic [31:0] wWriteData,
    input  logic [31:0] wReadData
);

    localparam int MAX_CYCLES = (READ_LATENCY > WRITE_CYCLES) ? READ_LATENCY : WRITE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt;
    logic          latWrite;
    logic [1:0]    latSize;
    logic          latUnsigned;
    logic [31:0]   latAddr;
    logic [31:0]   latWData;
    logic          reqMisaligned;
    logic          lastCycle;
    logic [3:0]    laneMask;
    logic [31:0]   shifted;
    logic [15:0]   halfLane;
    logic [31:0]   loadExt;

    // Size 11 behaves as a word everywhere, so iSize[1] alone selects word handling.
    assign reqMisaligned = ((iSize == 2'b01) && iAddr[0]) || (iSize[1] && (iAddr[1:0] != 2'b00));
    assign lastCycle     = (cnt == CW'(1));
    assign wAddress      = latAddr;

    always_comb begin
        laneMask   = 4'b1111;
        wWriteData = latWData;
        case (latSize)
            2'b00: begin
                laneMask   = 4'b0001 << latAddr[1:0];
                wWriteData = {4{latWData[7:0]}};
            end
            2'b01: begin
                laneMask   = latAddr[1] ? 4'b1100 : 4'b0011;
                wWriteData = {2{latWData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = wReadData >> {latAddr[1:0], 3'b000};
        halfLane = latAddr[1] ? wReadData[31:16] : wReadData[15:0];
        case (latSize)
            2'b00:   loadExt = {{24{~latUnsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   loadExt = {{16{~latUnsigned & halfLane[15]}}, halfLane};
            default: loadExt = wReadData;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        oBusy        = 1'b1;
        oDone        = 1'b0;
        oMisaligned  = 1'b0;
        wReadEnable  = 1'b0;
        wWriteEnable = 1'b0;
        wByteEnable  = 4'b0000;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iReq) begin
                    if (reqMisaligned) stateNext = ERR;
                    else if (iWrite)   stateNext = WRITE;
                    else               stateNext = READ;
                end
            end
            READ: begin
                wReadEnable = 1'b1;
                wByteEnable = laneMask;
                if (lastCycle) stateNext = RESP;
            end
            WRITE: begin
                wWriteEnable = 1'b1;
                wByteEnable  = laneMask;
                if (lastCycle) stateNext = RESP;
            end
            RESP: begin
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            ERR: begin
                oDone       = 1'b1;
                oMisaligned = 1'b1;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt         <= '0;
            latWrite    <= 1'b0;
            latSize     <= 2'b00;
            latUnsigned <= 1'b0;
            latAddr     <= '0;
            latWData    <= '0;
            oRData      <= '0;
        end else begin
            if (state == IDLE && iReq) begin
                latWrite    <= iWrite;
                latSize     <= iSize;
                latUnsigned <= iUnsigned;
                latAddr     <= iAddr;
                latWData    <= iWData;
                cnt         <= iWrite ? CW'(WRITE_CYCLES) : CW'(READ_LATENCY);
            end else if (state == READ || state == WRITE) begin
                cnt <= cnt - CW'(1);
            end
            // Read data is only meaningful on the final enable cycle.
            if (state == READ && lastCycle && !latWrite) begin
                oRData <= loadExt;
            end
        end
    end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
Bus initiator that drives the IO/memory bus (read/write enables, byte enables, address, write data; read data returned) on behalf of the core's load/store unit. It accepts one byte, halfword or word request at a time and generates the byte lanes and replicated write data. It waits a fixed number of bus cycles, then aligns and sign- or zero-extends read data. It sits between the datapath and the code/data memory interfaces, which act as responders on the same bus.

Parameters:
READ_LATENCY, 2, cycles wReadEnable stays asserted; read data is sampled on the last of them (must be >=1)
WRITE_CYCLES, 1, cycles wWriteEnable stays asserted (must be >=1)

Ports:
iCLK  input  1  system clock; all logic on rising edge
iRST  input  1  reset, synchronous, active-high
iReq  input  1  request strobe; sampled only in IDLE
iWrite  input  1  1=store, 0=load
iSize  input  2  00=byte, 01=half, 10=word, 11=treated as word
iUnsigned  input  1  loads: 1=zero-extend, 0=sign-extend
iAddr  input  32  byte address
iWData  input  32  store data, right-aligned
oBusy  output  1  high in every state except IDLE
oDone  output  1  one-cycle completion pulse
oMisaligned  output  1  valid with oDone; alignment fault
oRData  output  32  aligned, extended load result; held until next load completes
wReadEnable  output  1  bus read enable
wWriteEnable  output  1  bus write enable
wByteEnable  output  4  bus byte lanes
wAddress  output  32  bus address; the full latched iAddr, low bits not cleared
wWriteData  output  32  bus write data
wReadData  input  32  bus read data

Behaviour:
- Reset: state=IDLE. All outputs 0, including oRData and the counter. Reset during any state aborts the access: enables are 0 from the reset edge, no oDone pulse, and the request is lost.
- States: IDLE, READ, WRITE, RESP, ERR.
- IDLE: when iReq=1 at a clock edge, latch iWrite, iSize, iUnsigned, iAddr and iWData.
  - Misaligned request goes to ERR. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise go to WRITE if iWrite=1, else to READ. Load the counter with the state's cycle count.
- Byte enables: byte = 0001 shifted left by addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Write data: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- READ: wReadEnable=1 with the computed byte enables for READ_LATENCY cycles. On the last cycle, capture wReadData. Extract the lane (byte at addr[1:0]*8, half at addr[1]*16) and extend per iUnsigned into oRData. Then go to RESP.
- WRITE: wWriteEnable=1 with byte enables and write data for WRITE_CYCLES cycles, then go to RESP. oRData is unchanged.
- RESP: oDone=1 for one cycle, oMisaligned=0, then go to IDLE. iReq is ignored in RESP, so the minimum spacing between accepts is one IDLE cycle.
- ERR: oDone=1 and oMisaligned=1 for one cycle, no bus enables, oRData unchanged, then go to IDLE.
- Latency, with accept edge = cycle 0:
  - Read: enables in cycles 1..READ_LATENCY, oDone in cycle READ_LATENCY+1.
  - Write: enables in cycles 1..WRITE_CYCLES, oDone in cycle WRITE_CYCLES+1.
  - Fault: oDone in cycle 1.
- Outside READ and WRITE: wReadEnable=0, wWriteEnable=0, wByteEnable=0. wAddress and wWriteData hold their last values.
- Input changes while oBusy=1 have no effect.
- wReadEnable and wWriteEnable are never high in the same cycle.

Test Plan:
- Word load, iAddr=0x00400004, bus returns 0xDEADBEEF in cycle 2 (READ_LATENCY=2) -> wReadEnable=1 in cycles 1-2, wByteEnable=1111, oDone in cycle 3, oRData=0xDEADBEEF.
- Byte load, iAddr=0x00400003, bus 0x80112233 -> wByteEnable=1000. Signed gives oRData=0xFFFFFF80; unsigned gives 0x00000080.
- Half store, iAddr=0x00400006, iWData=0x1234ABCD -> wByteEnable=1100, wWriteData=0xABCDABCD, wWriteEnable high exactly 1 cycle, oDone in cycle 2.
- Misaligned word load, iAddr=0x00400002 -> no enable in any cycle, oDone=oMisaligned=1 in cycle 1, oRData keeps its previous value.
- iReq held high continuously across two loads -> second accepted in the IDLE cycle after RESP, and no re-accept during READ/RESP.
- iRST pulsed in cycle 1 of a read -> wReadEnable=0 and oBusy=0 from the next edge, no oDone pulse, oRData=0.
